uart_num_tx: RTL and testbench

- Serial transmitter that sends an 8-bit value as human-readable decimal text over UART.
- Output format: 8N1 frames, 9600 baud, ASCII digits with leading zeros suppressed, followed by CR LF.
- Fills the transmit side of the board's UART link, pairing with the receive path that drives the 7-segment number display.
- A value sent by this block and looped back shows on the digitron as the same number.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_tx_byte.sv | 59 +++++
 rtl/uart_num_tx.sv | 119 +++++++++++
 tb/tb_uart_num_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, message states and digit helpers
// for the decimal-text UART transmitter.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int DEF_BAUD_DIV = 5208;

  typedef enum logic [2:0] {
    IDLE,
    DIG_H,
    DIG_T,
    DIG_U,
    CR,
    LF
  } msg_state_t;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } digits_t;

  function automatic digits_t split_digits(
    input logic [7:0] v
  );
    digits_t d;
    d.h = 4'(v / 8'd100);
    d.t = 4'((v % 8'd100) / 8'd10);
    d.u = 4'(v % 8'd10);
    return d;
  endfunction

  function automatic logic [7:0] to_ascii(
    input logic [3:0] d
  );
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 frame serializer; byte_ready is high when
// idle or in the final cycle of the stop bit.
`timescale 1ns/1ps
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       TX_Out
);

  localparam logic [15:0] CNT_MAX  = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  STOP_IDX = 4'd9;

  logic       busy;
  logic [7:0] shreg;
  logic [15:0] cnt;
  logic [3:0] idx;
  logic       bit_end;
  logic       last;

  assign bit_end    = busy && (cnt == CNT_MAX);
  assign last       = bit_end && (idx == STOP_IDX);
  assign byte_ready = !busy || last;

  // idx is the frame bit on the line: 0 start, 1..8 data, 9 stop
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy   <= 1'b0;
      shreg  <= '0;
      cnt    <= '0;
      idx    <= '0;
      TX_Out <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      busy   <= 1'b1;
      shreg  <= byte_data;
      cnt    <= '0;
      idx    <= '0;
      TX_Out <= 1'b0;
    end else if (last) begin
      busy   <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      TX_Out <= 1'b1;
    end else if (bit_end) begin
      cnt    <= '0;
      idx    <= idx + 4'd1;
      TX_Out <= (idx == 4'd8) ? 1'b1 : shreg[idx[2:0]];
    end else if (busy) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_num_tx.sv
// Sends an 8-bit value as decimal ASCII text plus CR LF
// over 8N1 UART, leading zeros suppressed.
`timescale 1ns/1ps
module uart_num_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_Data,
  input  logic       TX_Start,
  output logic       TX_Busy,
  output logic       TX_Done,
  output logic       TX_Out
);

  msg_state_t state;
  msg_state_t state_nxt;
  digits_t    in_dig;
  logic [3:0] dig_t;
  logic [3:0] dig_u;
  logic       done_nxt;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;

  assign in_dig  = split_digits(TX_Data);
  assign TX_Busy = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      dig_t   <= '0;
      dig_u   <= '0;
      TX_Done <= 1'b0;
    end else begin
      state   <= state_nxt;
      TX_Done <= done_nxt;
      if (state == IDLE && TX_Start) begin
        dig_t <= in_dig.t;
        dig_u <= in_dig.u;
      end
    end
  end

  // Each state names the byte on the line; the next byte
  // is offered as that byte's stop bit ends.
  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    unique case (state)
      IDLE: begin
        if (TX_Start) begin
          byte_valid = 1'b1;
          if (in_dig.h != 4'd0) begin
            state_nxt = DIG_H;
            byte_data = to_ascii(in_dig.h);
          end else if (in_dig.t != 4'd0) begin
            state_nxt = DIG_T;
            byte_data = to_ascii(in_dig.t);
          end else begin
            state_nxt = DIG_U;
            byte_data = to_ascii(in_dig.u);
          end
        end
      end
      DIG_H: begin
        if (byte_ready) begin
          byte_valid = 1'b1;
          byte_data  = to_ascii(dig_t);
          state_nxt  = DIG_T;
        end
      end
      DIG_T: begin
        if (byte_ready) begin
          byte_valid = 1'b1;
          byte_data  = to_ascii(dig_u);
          state_nxt  = DIG_U;
        end
      end
      DIG_U: begin
        if (byte_ready) begin
          byte_valid = 1'b1;
          byte_data  = ASCII_CR;
          state_nxt  = CR;
        end
      end
      CR: begin
        if (byte_ready) begin
          byte_valid = 1'b1;
          byte_data  = ASCII_LF;
          state_nxt  = LF;
        end
      end
      LF: begin
        if (byte_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx_byte (
    .CLK        (CLK),
    .RST        (RST),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .TX_Out     (TX_Out)
  );

endmodule

// File: tb/tb_uart_num_tx.sv
// Bench for uart_num_tx: cycle-level line model driven
// by the decimal text of each accepted value.
`timescale 1ns/1ps
module tb_uart_num_tx;

  localparam int BD  = 4;
  localparam int BD2 = 5208;

  logic       CLK;
  logic       RST, RST2;
  logic [7:0] TX_Data, TX_Data2;
  logic       TX_Start, TX_Start2;
  logic       TX_Busy, TX_Done, TX_Out;
  logic       TX_Busy2, TX_Done2, TX_Out2;

  uart_num_tx #(.BAUD_DIV(BD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .TX_Data  (TX_Data),
    .TX_Start (TX_Start),
    .TX_Busy  (TX_Busy),
    .TX_Done  (TX_Done),
    .TX_Out   (TX_Out)
  );

  uart_num_tx dut2 (
    .CLK      (CLK),
    .RST      (RST2),
    .TX_Data  (TX_Data2),
    .TX_Start (TX_Start2),
    .TX_Busy  (TX_Busy2),
    .TX_Done  (TX_Done2),
    .TX_Out   (TX_Out2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int vec = 0;
  int errs = 0;

  // model of dut: current message text and cycle since accept
  string m_str = "";
  int    m_k = 0;
  bit    m_act = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] rx_log[$];
  int    runs[$];
  int    gaps[$];
  int    run = 0, idle_run = 0, done_cnt = 0;
  logic  pb = 0;
  bit    dact = 0;
  int    dcnt = 0;
  logic [7:0] dsh = 0;

  // model of dut2
  bit    d2_act = 0;
  int    d2_k = 0;
  bit    d2_dact = 0;
  int    d2_dcnt = 0;
  logic [7:0] d2_dsh = 0;
  logic [7:0] d2_first = 0;
  bit    d2_got = 0;
  int    zw = 0;
  bit    seen1 = 0;

  function automatic logic line_bit(string s, int k, int bd);
    int byt;
    int b;
    logic [7:0] c;
    byt = k / (10 * bd);
    b = (k / bd) % 10;
    c = s[byt];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return c[b-1];
  endfunction

  function automatic bit dec_step(
    input logic line, input int bd,
    inout bit act, inout int cnt, inout logic [7:0] sh,
    output logic [7:0] b, output logic stop_ok
  );
    int k;
    b = 8'h00;
    stop_ok = 1'b0;
    if (!act) begin
      if (line == 1'b0) begin
        act = 1;
        cnt = 0;
      end
      return 0;
    end
    cnt++;
    if (cnt % bd == bd / 2) begin
      k = cnt / bd;
      if (k >= 1 && k <= 8) sh[k-1] = line;
      if (k == 9) begin
        b = sh;
        stop_ok = line;
        act = 0;
        return 1;
      end
    end
    return 0;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_rx(string name, int mark, string want);
    int n;
    bit ok;
    n = rx_log.size() - mark;
    ok = (n == want.len());
    for (int i = 0; ok && i < n; i++)
      if (rx_log[mark+i] !== want[i]) ok = 0;
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d bytes, want %0d bytes", name, n, want.len());
      for (int i = 0; i < n && i < 12; i++)
        $display("  byte %0d got %02h", i, rx_log[mark+i]);
    end
  endtask

  task automatic tick();
    logic st, st2;
    logic [7:0] d, rb;
    logic so, eo, eb, ed;
    int total;
    @(posedge CLK);
    st = TX_Start;
    d = TX_Data;
    st2 = TX_Start2;
    total = m_str.len() * 10 * BD;
    if (!RST) begin
      if (st && (!m_act || m_k >= total)) begin
        m_str = $sformatf("%0d\r\n", d);
        m_k = 0;
        m_act = 1;
        for (int i = 0; i < m_str.len(); i++)
          exp_rx.push_back(m_str[i]);
      end else if (m_act) begin
        m_k++;
      end
    end
    if (!RST2) begin
      if (st2 && !d2_act) begin
        d2_act = 1;
        d2_k = 0;
      end else if (d2_act) begin
        d2_k++;
      end
    end
    #1;
    if (RST) begin
      m_act = 0;
      exp_rx.delete();
      dact = 0;
    end
    total = m_str.len() * 10 * BD;
    eo = 1'b1; eb = 1'b0; ed = 1'b0;
    if (m_act && m_k < total) begin
      eo = line_bit(m_str, m_k, BD);
      eb = 1'b1;
    end else if (m_act && m_k == total) begin
      ed = 1'b1;
    end
    chk("cycle out/busy/done", {29'd0, TX_Out, TX_Busy, TX_Done},
        {29'd0, eo, eb, ed});
    if (TX_Done) done_cnt++;
    if (TX_Busy) begin
      if (!pb) begin
        gaps.push_back(idle_run);
        run = 0;
      end
      run++;
    end else begin
      if (pb) begin
        runs.push_back(run);
        idle_run = 0;
      end
      idle_run++;
    end
    pb = TX_Busy;
    if (dec_step(TX_Out, BD, dact, dcnt, dsh, rb, so)) begin
      rx_log.push_back(rb);
      chk("stop bit", {31'd0, so}, 32'd1);
      if (exp_rx.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL rx extra byte: got %02h want none", rb);
      end else begin
        chk("rx byte", {24'd0, rb}, {24'd0, exp_rx.pop_front()});
      end
    end
    if (d2_act && d2_k <= 52100) begin
      chk("dut2 cycle", {29'd0, TX_Out2, TX_Busy2, TX_Done2},
          {29'd0, line_bit("100\r\n", d2_k, BD2), 2'b10});
      if (!seen1) begin
        if (TX_Out2 == 1'b0) zw++;
        else seen1 = 1;
      end
      if (!d2_got && dec_step(TX_Out2, BD2, d2_dact, d2_dcnt,
                              d2_dsh, rb, so)) begin
        d2_first = rb;
        d2_got = 1;
      end
    end
  endtask

  task automatic send(logic [7:0] v);
    TX_Data = v;
    TX_Start = 1'b1;
    tick();
    TX_Start = 1'b0;
  endtask

  task automatic wait_idle(int max);
    int i;
    i = 0;
    while (TX_Busy && i < max) begin
      tick();
      i++;
    end
    chk("idle within bound", {31'd0, TX_Busy}, 32'd0);
  endtask

  initial begin
    int mark, dc, n, guard;
    bit hold;
    RST = 1'b1; RST2 = 1'b1;
    TX_Data = 8'h00; TX_Start = 1'b0;
    TX_Data2 = 8'd100; TX_Start2 = 1'b0;
    repeat (3) tick();
    chk("reset out", {31'd0, TX_Out}, 32'd1);
    chk("reset busy", {31'd0, TX_Busy}, 32'd0);
    RST = 1'b0; RST2 = 1'b0;
    tick();
    TX_Start2 = 1'b1;
    tick();
    TX_Start2 = 1'b0;

    mark = rx_log.size(); dc = done_cnt;
    send(8'd0);
    wait_idle(400);
    tick();
    chk_rx("msg 0", mark, "0\r\n");
    chk("busy len 0", runs[$], 120);
    chk("done count 0", done_cnt - dc, 1);

    mark = rx_log.size(); dc = done_cnt;
    send(8'd42);
    wait_idle(400);
    tick();
    chk_rx("msg 42", mark, "42\r\n");
    chk("busy len 42", runs[$], 160);
    chk("done count 42", done_cnt - dc, 1);

    mark = rx_log.size();
    send(8'd105);
    n = 0;
    while (!TX_Done && n < 400) begin
      tick();
      n++;
    end
    chk("done seen 105", {31'd0, TX_Done}, 32'd1);
    TX_Data = 8'd255;
    TX_Start = 1'b1;
    tick();
    TX_Start = 1'b0;
    wait_idle(400);
    tick();
    chk_rx("msg 105 255", mark, "105\r\n255\r\n");
    chk("busy len 105", runs[runs.size()-2], 200);
    chk("busy len 255", runs[$], 200);
    chk("gap 105-255", gaps[$], 1);

    mark = rx_log.size(); dc = done_cnt;
    send(8'd77);
    repeat (50) tick();
    TX_Data = 8'd9;
    TX_Start = 1'b1;
    tick();
    TX_Start = 1'b0;
    TX_Data = 8'd200;
    wait_idle(400);
    repeat (60) tick();
    chk_rx("msg 77 ignore start", mark, "77\r\n");
    chk("done count 77", done_cnt - dc, 1);

    send(8'd255);
    repeat (30) tick();
    #2;
    RST = 1'b1;
    #1;
    chk("async rst out", {31'd0, TX_Out}, 32'd1);
    chk("async rst busy", {31'd0, TX_Busy}, 32'd0);
    chk("async rst done", {31'd0, TX_Done}, 32'd0);
    repeat (3) tick();
    RST = 1'b0;
    tick();
    mark = rx_log.size();
    send(8'd7);
    wait_idle(400);
    tick();
    chk_rx("msg 7 after rst", mark, "7\r\n");

    for (int it = 0; it < 25; it++) begin
      hold = ($urandom_range(0, 3) == 0);
      send(8'($urandom_range(0, 255)));
      n = $urandom_range(1, 400);
      for (int c = 0; c < n; c++) begin
        TX_Data = 8'($urandom);
        TX_Start = hold | ($urandom_range(0, 15) == 0);
        tick();
      end
      TX_Start = 1'b0;
      wait_idle(1000);
      tick();
    end

    guard = 0;
    while (d2_k < 52100 && guard < 60000) begin
      tick();
      guard++;
    end
    chk("dut2 first byte", {24'd0, d2_first}, 32'h31);
    chk("dut2 start width", zw, BD2);
    chk("dut2 still busy", {31'd0, TX_Busy2}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
